// File: rtl/polyphase_slicer.sv
// polyphase_slicer
//   Symbol-rate decimator and slicer placed after the TX/RX FIR. Collects OS
//   filter samples per symbol, picks one programmable phase and slices it to
//   a PAM2 or PAM4 symbol. Phase/mode requests are latched only at symbol
//   boundaries, so a change never tears a symbol.
// Ports
//   clock        in   system clock, rising edge
//   i_reset      in   asynchronous reset, active high
//   i_enable     in   global enable, low freezes all state
//   i_data       in   signed filter sample (NB_DATA)
//   i_valid      in   i_data valid this cycle
//   i_align      in   restart symbol framing (accepted sample becomes count 0)
//   i_phase      in   requested sampling phase 0..OS-1
//   i_mode       in   requested slicer mode, 0 PAM2 / 1 PAM4
//   o_symbol     out  sliced symbol (PAM2 uses bit 0)
//   o_sample     out  raw selected sample behind o_symbol
//   o_valid      out  one-cycle pulse per symbol
//   o_phase_err  out  sticky: out-of-range phase seen at a boundary
module polyphase_slicer #(
  parameter int NB_DATA  = 8,
  parameter int OS       = 4,
  parameter int NB_SEL   = 2,
  parameter int PAM4_THR = 32
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_align,
  input  logic [NB_SEL-1:0]  i_phase,
  input  logic               i_mode,
  output logic [1:0]         o_symbol,
  output logic [NB_DATA-1:0] o_sample,
  output logic               o_valid,
  output logic               o_phase_err
);

  localparam logic [NB_SEL-1:0] LAST = NB_SEL'(OS - 1);
  // Thresholds carry one extra bit so -PAM4_THR and the most negative
  // sample compare without wrapping.
  localparam logic signed [NB_DATA:0] THR_P = (NB_DATA + 1)'(PAM4_THR);
  localparam logic signed [NB_DATA:0] THR_N = -THR_P;

  // dline[0] is the previous accepted sample; dline[k] is k+1 samples old.
  logic [OS-2:0][NB_DATA-1:0] dline;
  logic [NB_SEL-1:0]          count, act_phase;
  logic                       act_mode;

  logic                       accept, strobe, phase_ok;
  logic [NB_DATA-1:0]         sel;
  logic signed [NB_DATA:0]    s_ext;
  logic [1:0]                 sym;

  assign accept   = i_enable & i_valid;
  assign strobe   = accept & (count == LAST) & ~i_align;
  assign phase_ok = ({1'b0, i_phase} < (NB_SEL + 1)'(OS));

  // At a strobe the newest sample (count OS-1) is i_data and dline[k]
  // holds count OS-2-k.
  always_comb begin
    sel = i_data;
    for (int k = 0; k < OS - 1; k++)
      if (act_phase == NB_SEL'(OS - 2 - k)) sel = dline[k];
  end

  always_comb begin
    s_ext = {sel[NB_DATA-1], sel};
    sym   = 2'b00;
    if (!act_mode)               sym = s_ext[NB_DATA] ? 2'b00 : 2'b01;
    else if (s_ext < THR_N)      sym = 2'b00;
    else if (s_ext[NB_DATA])     sym = 2'b01;
    else if (s_ext < THR_P)      sym = 2'b11;
    else                         sym = 2'b10;
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      dline       <= '0;
      count       <= '0;
      act_phase   <= '0;
      act_mode    <= 1'b0;
      o_symbol    <= 2'b00;
      o_sample    <= '0;
      o_valid     <= 1'b0;
      o_phase_err <= 1'b0;
    end else if (i_enable) begin
      o_valid <= strobe;
      if (strobe) begin
        // Emitted symbol uses the old phase/mode; new ones apply next frame.
        o_symbol <= sym;
        o_sample <= sel;
        act_mode <= i_mode;
        if (phase_ok) act_phase   <= i_phase;
        else          o_phase_err <= 1'b1;
      end
      if (accept) begin
        for (int k = OS - 2; k > 0; k--) dline[k] <= dline[k-1];
        dline[0] <= i_data;
      end
      // Align with an accept makes this sample count 0, so the next is 1.
      if (i_align)     count <= accept ? NB_SEL'(1) : '0;
      else if (accept) count <= (count == LAST) ? '0 : count + NB_SEL'(1);
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_polyphase_slicer.sv
// Bench for polyphase_slicer: one OS=4 instance (main) and one OS=3 instance
// sharing all stimulus, so a 2-bit phase of 3 is out of range for the latter.
// Reference model collects accepted samples into a frame buffer and slices
// the chosen entry with plain integer thresholds.
module tb_polyphase_slicer;
  logic              clock = 1'b0;
  logic              rst, en, vld, aln, mode;
  logic [1:0]        ph;
  logic signed [7:0] din;
  logic [1:0]        sym0, sym1;
  logic signed [7:0] smp0, smp1;
  logic              v0, v1, err0, err1;

  polyphase_slicer #(.NB_DATA(8), .OS(4), .NB_SEL(2), .PAM4_THR(32)) dut4 (
    .clock(clock), .i_reset(rst), .i_enable(en), .i_data(din), .i_valid(vld),
    .i_align(aln), .i_phase(ph), .i_mode(mode), .o_symbol(sym0),
    .o_sample(smp0), .o_valid(v0), .o_phase_err(err0));

  polyphase_slicer #(.NB_DATA(8), .OS(3), .NB_SEL(2), .PAM4_THR(32)) dut3 (
    .clock(clock), .i_reset(rst), .i_enable(en), .i_data(din), .i_valid(vld),
    .i_align(aln), .i_phase(ph), .i_mode(mode), .o_symbol(sym1),
    .o_sample(smp1), .o_valid(v1), .o_phase_err(err1));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  // reference model state, index 0 = OS 4, index 1 = OS 3
  int os_[2] = '{4, 3};
  int fb[2][4];
  int fc[2], mph[2], esym[2], esmp[2];
  bit mmd[2], merr[2], ev[2];

  function automatic int slice(input int s, input bit m);
    if (!m) return (s >= 0) ? 1 : 0;
    if (s < -32) return 0;
    if (s < 0)   return 1;
    if (s < 32)  return 3;
    return 2;
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      fc[d] = 0; mph[d] = 0; mmd[d] = 0; merr[d] = 0;
      ev[d] = 0; esym[d] = 0; esmp[d] = 0;
    end
  endtask

  task automatic mstep(input int d);
    ev[d] = 0;
    if (!en) return;
    if (aln) fc[d] = 0;
    if (!vld) return;
    fb[d][fc[d]] = int'(din);
    fc[d]++;
    if (fc[d] == os_[d]) begin
      esmp[d] = fb[d][mph[d]];
      esym[d] = slice(esmp[d], mmd[d]);
      ev[d]   = 1;
      if (int'(ph) >= os_[d]) merr[d] = 1;
      else                    mph[d]  = int'(ph);
      mmd[d] = mode;
      fc[d]  = 0;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkall();
    chk("valid4", int'(v0), int'(ev[0]));
    chk("sym4",   int'(sym0), esym[0]);
    chk("smp4",   int'(smp0), esmp[0]);
    chk("err4",   int'(err0), int'(merr[0]));
    chk("valid3", int'(v1), int'(ev[1]));
    chk("sym3",   int'(sym1), esym[1]);
    chk("smp3",   int'(smp1), esmp[1]);
    chk("err3",   int'(err1), int'(merr[1]));
  endtask

  task automatic cycle();
    @(posedge clock);
    if (rst) mreset();
    else begin mstep(0); mstep(1); end
    #1 checkall();
  endtask

  task automatic send(input int v, input bit a);
    en = 1'b1; vld = 1'b1; aln = a; din = v[7:0];
    cycle();
    aln = 1'b0;
  endtask

  task automatic idle(input bit a);
    en = 1'b1; vld = 1'b0; aln = a;
    cycle();
    aln = 1'b0;
  endtask

  // Async reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 mreset();
    checkall();
    chk("rst_valid", int'(v0), 0);
    chk("rst_sym",   int'(sym0), 0);
    cycle();
    rst = 1'b0;
  endtask

  int pv[6] = '{-33, -32, -1, 0, 31, 32};
  int ps[6] = '{0, 1, 1, 3, 3, 2};

  initial begin
    rst = 1'b1; en = 1'b0; vld = 1'b0; aln = 1'b0; mode = 1'b0; ph = 2'd0;
    din = '0;
    #1 mreset();
    checkall();
    cycle();
    rst = 1'b0;
    // three frames of idle: no symbols
    repeat (12) idle(1'b0);

    // PAM2, phase 2, stream +5,-3,-7,+1
    ph = 2'd2; mode = 1'b0;
    send(5, 1); send(-3, 0); send(-7, 0); send(1, 0);
    repeat (3) begin
      send(5, 0); send(-3, 0); send(-7, 0);
      chk("pam2_gap", int'(v0), 0);
      send(1, 0);
      chk("pam2_valid", int'(v0), 1);
      chk("pam2_smp", int'(smp0), -7);
      chk("pam2_sym", int'(sym0), 0);
    end

    // phase 1 -> 3 mid-frame
    ph = 2'd1;
    send(11, 1); send(12, 0); send(13, 0); send(14, 0);
    send(20, 0); send(21, 0); ph = 2'd3; send(22, 0); send(23, 0);
    chk("phchg_old", int'(smp0), 21);
    send(30, 0); send(31, 0); send(32, 0); send(33, 0);
    chk("phchg_new", int'(smp0), 33);

    // PAM4 thresholds, phase 3
    mode = 1'b1;
    send(1, 1); send(2, 0); send(3, 0); send(4, 0);
    for (int i = 0; i < 6; i++) begin
      send(int'($urandom_range(255)), 1);
      send(int'($urandom_range(255)), 0);
      send(int'($urandom_range(255)), 0);
      send(pv[i], 0);
      chk("pam4_sym", int'(sym0), ps[i]);
    end
    chk("phase_err_os3", int'(err1), 1);
    chk("phase_err_os4", int'(err0), 0);

    // valid gaps and enable low mid-frame, then realign
    send(-128, 1); send(-128, 0);
    en = 1'b0;
    repeat (7) begin
      vld = 1'($urandom); aln = 1'($urandom); din = 8'($urandom);
      cycle();
    end
    aln = 1'b0;
    idle(1'b0); idle(1'b0);
    idle(1'b1);
    send(-128, 0); send(-128, 0); send(-128, 0);
    chk("realign_early", int'(v0), 0);
    send(-128, 0);
    chk("realign_valid", int'(v0), 1);
    chk("neg_full_sym", int'(sym0), 0);
    chk("neg_full_smp", int'(smp0), -128);

    // randomized traffic with a reset in the middle
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      en   = ($urandom_range(9) != 0);
      vld  = ($urandom_range(4) != 0);
      aln  = ($urandom_range(30) == 0);
      ph   = 2'($urandom);
      mode = 1'($urandom);
      din  = 8'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
